// File: rtl/remocon_ir_tx.sv
// remocon_ir_tx -- handheld IR remote transmitter (channel up/down).
//
// Sends one pulse-distance frame per button press: 8 units lead mark,
// 4 units lead space, 24 bits (mark 1 unit, space 1 unit for '0' or
// 3 units for '1'), then a 1-unit trailing mark. The bits go out LSB
// first as ADDR, cmd, ~cmd. Presses seen while a frame is in flight are
// dropped.
//
// Ports:
//   clk      in   system clock
//   rst      in   synchronous reset, active-high
//   up       in   channel-up button (level, debounced)
//   down     in   channel-down button (level, debounced)
//   ir_out   out  IR LED drive, 1 = mark
//   busy     out  high while a frame is in flight
//   done     out  one-cycle pulse after the trailing mark
//   last_cmd out  command of the most recently started frame
//
// Build option: define CARRIER_EN to modulate marks with a 50% carrier
// of period CARRIER_DIV clocks. Otherwise marks are a steady 1 (baseband).

module remocon_ir_tx #(
   parameter int         UNIT_CYC    = 1000,
   parameter logic [7:0] ADDR        = 8'h5A,
   parameter logic [7:0] CMD_UP      = 8'h01,
   parameter logic [7:0] CMD_DOWN    = 8'h02,
   parameter int         CARRIER_DIV = 26
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       up,
   input  logic       down,
   output logic       ir_out,
   output logic       busy,
   output logic       done,
   output logic [7:0] last_cmd
);

   localparam int            UW       = (UNIT_CYC > 1) ? $clog2(UNIT_CYC) : 1;
   localparam logic [UW-1:0] UNIT_MAX = UW'(UNIT_CYC - 1);

   localparam logic [2:0] S_IDLE       = 3'd0;
   localparam logic [2:0] S_LEAD_MARK  = 3'd1;
   localparam logic [2:0] S_LEAD_SPACE = 3'd2;
   localparam logic [2:0] S_BIT_MARK   = 3'd3;
   localparam logic [2:0] S_BIT_SPACE  = 3'd4;
   localparam logic [2:0] S_TRAIL_MARK = 3'd5;

   logic [2:0]    r_state;
   logic [2:0]    w_next;
   logic [UW-1:0] r_ucnt;
   logic [3:0]    r_units;     // units elapsed in the current state
   logic [3:0]    w_dur;       // length of the current state in units
   logic [4:0]    r_bitcnt;
   logic [23:0]   r_shift;
   logic          r_up_q;
   logic          r_down_q;
   logic          r_done;
   logic [7:0]    r_last_cmd;

   logic          w_up_edge;
   logic          w_down_edge;
   logic          w_accept;
   logic [7:0]    w_cmd;
   logic          w_unit_wrap;
   logic          w_state_end;
   logic          w_mark;

   assign w_up_edge   = up & ~r_up_q;
   assign w_down_edge = down & ~r_down_q;
   assign w_accept    = (r_state == S_IDLE) && (w_up_edge || w_down_edge);
   // Up wins when both buttons edge in the same cycle.
   assign w_cmd       = w_up_edge ? CMD_UP : CMD_DOWN;

   assign w_unit_wrap = (r_ucnt == UNIT_MAX);
   assign w_state_end = w_unit_wrap && (r_units == (w_dur - 4'd1));

   always_comb begin
      w_dur = 4'd1;
      case (r_state)
         S_LEAD_MARK:  w_dur = 4'd8;
         S_LEAD_SPACE: w_dur = 4'd4;
         S_BIT_SPACE:  w_dur = r_shift[0] ? 4'd3 : 4'd1;
         default:      w_dur = 4'd1;
      endcase
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:       if (w_accept)    w_next = S_LEAD_MARK;
         S_LEAD_MARK:  if (w_state_end) w_next = S_LEAD_SPACE;
         S_LEAD_SPACE: if (w_state_end) w_next = S_BIT_MARK;
         S_BIT_MARK:   if (w_state_end) w_next = S_BIT_SPACE;
         S_BIT_SPACE:  if (w_state_end) w_next = (r_bitcnt == 5'd23) ? S_TRAIL_MARK : S_BIT_MARK;
         S_TRAIL_MARK: if (w_state_end) w_next = S_IDLE;
         default:                       w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_ucnt     <= '0;
         r_units    <= '0;
         r_bitcnt   <= '0;
         r_shift    <= '0;
         r_done     <= 1'b0;
         r_last_cmd <= 8'h00;
         // Held buttons at reset release must not look like presses.
         r_up_q     <= 1'b1;
         r_down_q   <= 1'b1;
      end else begin
         r_up_q   <= up;
         r_down_q <= down;
         r_state  <= w_next;
         r_done   <= (r_state == S_TRAIL_MARK) && w_state_end;
         if (w_accept) begin
            r_shift    <= {~w_cmd, w_cmd, ADDR};
            r_last_cmd <= w_cmd;
            r_bitcnt   <= '0;
            r_ucnt     <= '0;
            r_units    <= '0;
         end else if (r_state != S_IDLE) begin
            if (w_unit_wrap) begin
               r_ucnt  <= '0;
               r_units <= w_state_end ? 4'd0 : r_units + 4'd1;
            end else begin
               r_ucnt  <= r_ucnt + 1'b1;
            end
            if ((r_state == S_BIT_SPACE) && w_state_end) begin
               r_shift  <= r_shift >> 1;
               r_bitcnt <= r_bitcnt + 5'd1;
            end
         end
      end
   end

   assign w_mark = (r_state == S_LEAD_MARK) || (r_state == S_BIT_MARK) ||
                   (r_state == S_TRAIL_MARK);

`ifdef CARRIER_EN
   localparam int CW = (CARRIER_DIV > 1) ? $clog2(CARRIER_DIV) : 1;
   logic [CW-1:0] r_car;

   // Restart at phase 0 on every state change so each mark begins high.
   always_ff @(posedge clk) begin
      if (rst || (w_next != r_state))
         r_car <= '0;
      else if (r_car == CW'(CARRIER_DIV - 1))
         r_car <= '0;
      else
         r_car <= r_car + 1'b1;
   end

   assign ir_out = w_mark && (r_car < CW'(CARRIER_DIV / 2));
`else
   assign ir_out = w_mark;
`endif

   assign busy     = (r_state != S_IDLE);
   assign done     = r_done;
   assign last_cmd = r_last_cmd;

endmodule

// File: tb/tb_remocon_ir_tx.sv
// Bench for remocon_ir_tx: two instances (ADDR 5A and ADDR 00, UNIT_CYC=10)
// share the button inputs. Frames from the 5A instance are decoded from
// run lengths of ir_out; the 00 instance checks total busy/mark time.
module tb_remocon_ir_tx;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       up = 1'b0;
   logic       down = 1'b0;
   logic       ir_out, busy, done;
   logic [7:0] last_cmd;
   logic       ir0, busy0, done0;
   logic [7:0] last0;

   remocon_ir_tx #(.UNIT_CYC(10), .ADDR(8'h5A), .CMD_UP(8'h01), .CMD_DOWN(8'h02), .CARRIER_DIV(26))
   u_dut (.clk(clk), .rst(rst), .up(up), .down(down), .ir_out(ir_out), .busy(busy),
          .done(done), .last_cmd(last_cmd));

   remocon_ir_tx #(.UNIT_CYC(10), .ADDR(8'h00), .CMD_UP(8'h01), .CMD_DOWN(8'h02), .CARRIER_DIV(26))
   u_dut0 (.clk(clk), .rst(rst), .up(up), .down(down), .ir_out(ir0), .busy(busy0),
           .done(done0), .last_cmd(last0));

   always #5 clk = ~clk;

   int          n_cmp = 0;
   int          n_bad = 0;
   int          runs [0:63];
   int          nruns, busy_cyc, busy0_cyc, high0, done_cnt, done0_cnt, bad_w;
   logic [23:0] word;

   typedef struct {
      logic        up;
      logic        dn;
      logic [7:0]  cmd;
      logic [23:0] word;
      int          busy;
      int          busy0;
   } vec_t;
   vec_t vt [3];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Observe 900 cycles after a press; optionally inject a second press.
   task automatic capture(input int inj_cyc, input logic inj_up, input logic inj_dn);
      int   len;
      logic prev;
      nruns = 0; busy_cyc = 0; busy0_cyc = 0; high0 = 0; done_cnt = 0; done0_cnt = 0;
      len = 0; prev = 1'b0;
      for (int c = 0; c < 900; c++) begin
         @(negedge clk);
         if (busy)  busy_cyc++;
         if (busy0) busy0_cyc++;
         if (ir0)   high0++;
         if (done)  done_cnt++;
         if (done0) done0_cnt++;
         if (busy) begin
            if (len > 0 && ir_out != prev) begin
               if (nruns < 64) runs[nruns] = len;
               nruns++;
               len = 0;
            end
            len++;
            prev = ir_out;
         end else if (len > 0) begin
            if (nruns < 64) runs[nruns] = len;
            nruns++;
            len = 0;
         end
         if (c == 0) begin up = 1'b0; down = 1'b0; end
         if (c == inj_cyc) begin up = inj_up; down = inj_dn; end
         if (c == inj_cyc + 3) begin up = 1'b0; down = 1'b0; end
      end
      word  = '0;
      bad_w = 0;
      if (nruns == 51) begin
         for (int b = 0; b < 24; b++) begin
            if (runs[2+2*b] != 10) bad_w++;
            if (runs[3+2*b] == 30) word[b] = 1'b1;
            else if (runs[3+2*b] != 10) bad_w++;
         end
      end else begin
         bad_w = 99;
      end
   endtask

   initial begin
      vt[0] = '{up: 1'b1, dn: 1'b0, cmd: 8'h01, word: 24'hFE015A, busy: 850, busy0: 770};
      vt[1] = '{up: 1'b1, dn: 1'b1, cmd: 8'h01, word: 24'hFE015A, busy: 850, busy0: 770};
      vt[2] = '{up: 1'b0, dn: 1'b1, cmd: 8'h02, word: 24'hFD025A, busy: 850, busy0: 770};

      // Reset with up held, then release: no frame.
      up = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_ir_out", ir_out, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_last_cmd", last_cmd, 8'h00);
      rst = 1'b0;
      busy_cyc = 0;
      for (int c = 0; c < 500; c++) begin
         @(negedge clk);
         if (busy || done) busy_cyc++;
      end
      chk("held_up_no_frame", busy_cyc, 0);
      up = 1'b0;
      repeat (2) @(negedge clk);

      for (int i = 0; i < 3; i++) begin
         up   = vt[i].up;
         down = vt[i].dn;
         capture(-1, 1'b0, 1'b0);
         chk($sformatf("v%0d_word", i), word, vt[i].word);
         chk($sformatf("v%0d_widths", i), bad_w, 0);
         chk($sformatf("v%0d_lead_mark", i), runs[0], 80);
         chk($sformatf("v%0d_lead_space", i), runs[1], 40);
         chk($sformatf("v%0d_trail", i), runs[50], 10);
         chk($sformatf("v%0d_last_cmd", i), last_cmd, vt[i].cmd);
         chk($sformatf("v%0d_busy", i), busy_cyc, vt[i].busy);
         chk($sformatf("v%0d_done", i), done_cnt, 1);
         chk($sformatf("v%0d_busy0", i), busy0_cyc, vt[i].busy0);
         chk($sformatf("v%0d_mark0", i), high0, 330);
         chk($sformatf("v%0d_done0", i), done0_cnt, 1);
         chk($sformatf("v%0d_last0", i), last0, vt[i].cmd);
      end

      // Down press 200 cycles into an up frame is dropped.
      up = 1'b1;
      capture(200, 1'b0, 1'b1);
      chk("inj_word", word, 24'hFE015A);
      chk("inj_last_cmd", last_cmd, 8'h01);
      chk("inj_done", done_cnt, 1);
      chk("inj_busy", busy_cyc, 850);

      // Reset during bit 10 (frame cycles 420..439).
      up = 1'b1;
      @(negedge clk);
      up = 1'b0;
      repeat (424) @(negedge clk);
      chk("mid_busy_before", busy, 1);
      rst = 1'b1;
      @(negedge clk);
      chk("mid_rst_ir_out", ir_out, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_last_cmd", last_cmd, 8'h00);
      rst = 1'b0;
      done_cnt = 0;
      busy_cyc = 0;
      for (int c = 0; c < 900; c++) begin
         @(negedge clk);
         if (done) done_cnt++;
         if (busy) busy_cyc++;
      end
      chk("mid_rst_no_done", done_cnt, 0);
      chk("mid_rst_idle", busy_cyc, 0);

      down = 1'b1;
      capture(-1, 1'b0, 1'b0);
      chk("post_rst_word", word, 24'hFD025A);
      chk("post_rst_widths", bad_w, 0);
      chk("post_rst_done", done_cnt, 1);
      chk("post_rst_last_cmd", last_cmd, 8'h02);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
